// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Optional feature macro: WB_BYPASS_EN (youngest-data bypass for hazard logic).
package reg_writeback_queue_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // x0 is hardwired to zero, so it never counts as a pending destination
  function automatic logic rd_match(input logic [REG_AW-1:0] entry_rd,
                                    input logic [REG_AW-1:0] query_rd);
    return (entry_rd == query_rd) && (query_rd != '0);
  endfunction

endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// Write-back entry FIFO: DEPTH-entry circular buffer, two pushes and one pop per cycle,
// per-entry valid bits exposed for scoreboard lookup.
// Optional feature macro: WB_BYPASS_EN (exports entry data and head pointer for age-ordered bypass).
module reg_writeback_queue_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push0_valid,
  input  wb_entry_t                 push0_entry,
  input  logic                      push1_valid,
  input  wb_entry_t                 push1_entry,
  input  logic                      pop,
  output wb_entry_t                 head_entry,
  output logic [DEPTH-1:0]          entry_valid,
  output logic [REG_AW-1:0]         entry_rd [DEPTH],
`ifdef WB_BYPASS_EN
  output logic [XLEN-1:0]           entry_data [DEPTH],
  output logic [$clog2(DEPTH)-1:0]  head_ptr,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        entry_q [DEPTH];
  wb_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    slot;
  logic [CW-1:0]    count_q, count_d;

  // Retire the head, then place push0 ahead of push1 so program order is kept
  always_comb begin
    entry_d  = entry_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    slot     = wr_ptr_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push0_valid) begin
      entry_d[slot] = push0_entry;
      valid_d[slot] = 1'b1;
      slot          = slot + PW'(1);
    end
    if (push1_valid) begin
      entry_d[slot] = push1_entry;
      valid_d[slot] = 1'b1;
      slot          = slot + PW'(1);
    end
    wr_ptr_d = slot;
    count_d  = count_q + CW'(push0_valid) + CW'(push1_valid) - CW'(pop);
  end

  // Storage, pointers and occupancy; reset discards every queued entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entry_q  <= entry_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Expose destination fields of every slot for the pending-write scoreboard
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_rd[i] = entry_q[i].rd;
  end

`ifdef WB_BYPASS_EN
  // Expose data fields of every slot for the bypass mux
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_data[i] = entry_q[i].data;
  end
  assign head_ptr = rd_ptr_q;
`endif

  assign head_entry  = entry_q[rd_ptr_q];
  assign entry_valid = valid_q;
  assign count       = count_q;

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-side front end of the integer register file: accepts ALU and load results,
// queues them in order and drains one per cycle onto the file's write port.
// Optional feature macro: WB_BYPASS_EN (youngest queued data returned for rs1/rs2).
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [REG_AW-1:0]       alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [REG_AW-1:0]       ld_rd,
  input  logic [XLEN-1:0]         ld_data,
  output logic                    rf_we,
  output logic [REG_AW-1:0]       rf_rd,
  output logic [XLEN-1:0]         rf_din,
  input  logic [REG_AW-1:0]       chk_rs1,
  input  logic [REG_AW-1:0]       chk_rs2,
  output logic                    chk_busy1,
  output logic                    chk_busy2,
  output logic                    byp_hit1,
  output logic                    byp_hit2,
  output logic [XLEN-1:0]         byp_data1,
  output logic [XLEN-1:0]         byp_data2,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              push0_valid, push1_valid;
  wb_entry_t         push0_entry, push1_entry;
  wb_entry_t         head_entry;
  logic [DEPTH-1:0]  entry_valid;
  logic [REG_AW-1:0] entry_rd [DEPTH];
  logic [CW-1:0]     free_slots;
`ifdef WB_BYPASS_EN
  logic [XLEN-1:0]   entry_data [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     age_idx;
`endif

  // Handshake from the registered count only; ALU takes the last free slot, x0 writes are dropped
  always_comb begin
    free_slots  = CW'(DEPTH) - q_count;
    alu_ready   = (free_slots >= CW'(1));
    ld_ready    = (free_slots >= CW'(2)) || ((free_slots == CW'(1)) && !alu_valid);
    push0_valid = alu_valid && alu_ready && (alu_rd != '0);
    push1_valid = ld_valid && ld_ready && (ld_rd != '0);
    push0_entry = '{rd: alu_rd, data: alu_data};
    push1_entry = '{rd: ld_rd, data: ld_data};
  end

  reg_writeback_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0_valid (push0_valid),
    .push0_entry (push0_entry),
    .push1_valid (push1_valid),
    .push1_entry (push1_entry),
    .pop         (rf_we),
    .head_entry  (head_entry),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd),
`ifdef WB_BYPASS_EN
    .entry_data  (entry_data),
    .head_ptr    (head_ptr),
`endif
    .count       (q_count)
  );

  // Drain the head every cycle the queue holds anything; idle port reads as zero
  always_comb begin
    rf_we  = (q_count != '0);
    rf_rd  = rf_we ? head_entry.rd : '0;
    rf_din = rf_we ? head_entry.data : '0;
  end

  // Pending-write scoreboard: any valid entry targeting the queried register
  always_comb begin
    chk_busy1 = 1'b0;
    chk_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && rd_match(entry_rd[i], chk_rs1)) chk_busy1 = 1'b1;
      if (entry_valid[i] && rd_match(entry_rd[i], chk_rs2)) chk_busy2 = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Walk from oldest to youngest so the last match, the youngest write, wins
  always_comb begin
    byp_data1 = '0;
    byp_data2 = '0;
    age_idx   = head_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = head_ptr + PW'(k);
      if (entry_valid[age_idx] && rd_match(entry_rd[age_idx], chk_rs1)) byp_data1 = entry_data[age_idx];
      if (entry_valid[age_idx] && rd_match(entry_rd[age_idx], chk_rs2)) byp_data2 = entry_data[age_idx];
    end
  end
  assign byp_hit1 = chk_busy1;
  assign byp_hit2 = chk_busy2;
`else
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule
